// File: rtl/count_pkg.sv
// ============================================================================
// Module   : count_pkg
// Purpose  : Shared types and constants for the count8 interval sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package count_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/count_seq.sv
// ============================================================================
// Module   : count_seq
// Purpose  : Drives load/EN of an external count8 counter across a commanded
//            start..end interval, with one-shot/auto-reload, hold and abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module count_seq
    import count_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int INT_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             mode,
    input  logic             hold,
    input  logic             abort,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] end_val,
    input  logic [WIDTH-1:0] CNT,
    output logic             CNT_EN,
    output logic             CNT_load,
    output logic [WIDTH-1:0] CNT_In,
    output logic             busy,
    output logic             done,
    output logic [INT_W-1:0] int_cnt
);

    localparam logic [INT_W-1:0] C_INT_ONE = {{(INT_W-1){1'b0}}, 1'b1};
    localparam logic [INT_W-1:0] C_INT_MAX = {INT_W{1'b1}};

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   sv_q,      sv_d;
    logic [WIDTH-1:0]   ev_q,      ev_d;
    logic               mode_q,    mode_d;
    logic [INT_W-1:0]   int_cnt_q, int_cnt_d;
    logic               done_q,    done_d;

    logic               w_match;
    logic [INT_W-1:0]   w_int_inc;

    assign w_match   = (CNT == ev_q);
    assign w_int_inc = (int_cnt_q == C_INT_MAX) ? int_cnt_q : (int_cnt_q + C_INT_ONE);

    always_comb begin
        state_d   = state_q;
        sv_d      = sv_q;
        ev_d      = ev_q;
        mode_d    = mode_q;
        int_cnt_d = int_cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    sv_d      = start_val;
                    ev_d      = end_val;
                    mode_d    = mode;
                    int_cnt_d = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Abort outranks a same-cycle match, match outranks hold.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (w_match) begin
                    done_d    = 1'b1;
                    int_cnt_d = w_int_inc;
                    state_d   = (mode_q == MODE_RELOAD) ? ST_LOAD : ST_DONE;
                end else if (hold) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!hold) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= ST_IDLE;
            sv_q      <= '0;
            ev_q      <= '0;
            mode_q    <= MODE_ONESHOT;
            int_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sv_q      <= sv_d;
            ev_q      <= ev_d;
            mode_q    <= mode_d;
            int_cnt_q <= int_cnt_d;
            done_q    <= done_d;
        end
    end

    // Enable is decoded straight from CNT so the counter halts exactly on ev.
    assign CNT_EN   = (state_q == ST_RUN) && !hold && !w_match && !abort;
    assign CNT_load = (state_q == ST_LOAD) && !abort;
    assign CNT_In   = sv_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign int_cnt  = int_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_count_seq.sv
// ============================================================================
// Module   : tb_count_seq
// Purpose  : Self-checking bench for count_seq with a count8 counter model
//            closing the CNT feedback loop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_count_seq;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] start_val = 8'h00;
    logic [7:0] end_val = 8'h00;
    logic [7:0] cnt;
    logic       cnt_en;
    logic       cnt_load;
    logic [7:0] cnt_in;
    logic       busy;
    logic       done;
    logic [7:0] int_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // count8 sibling: load beats EN, wraps mod 256.
    always_ff @(posedge clk) begin
        if (res)           cnt <= 8'h00;
        else if (cnt_load) cnt <= cnt_in;
        else if (cnt_en)   cnt <= cnt + 8'd1;
    end

    count_seq #(.WIDTH(8), .INT_W(8)) dut (
        .clk      (clk),
        .res      (res),
        .start    (start),
        .mode     (mode),
        .hold     (hold),
        .abort    (abort),
        .start_val(start_val),
        .end_val  (end_val),
        .CNT      (cnt),
        .CNT_EN   (cnt_en),
        .CNT_load (cnt_load),
        .CNT_In   (cnt_in),
        .busy     (busy),
        .done     (done),
        .int_cnt  (int_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (the LOAD cycle) of the new command.
    task automatic do_start(input logic [7:0] sv, input logic [7:0] ev, input logic m);
        start_val = sv;
        end_val   = ev;
        mode      = m;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        step();
        step();
        res = 1'b0;
        checks++;
        if ({busy, done, cnt_en, cnt_load} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl got busy/done/en/load=%b want 0000", {busy, done, cnt_en, cnt_load});
        end
        checks++;
        if (cnt_in !== 8'h00 || int_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got CNT_In=%h int_cnt=%h want 00/00", cnt_in, int_cnt);
        end
    endtask

    task automatic test_oneshot();
        do_start(8'h11, 8'h15, 1'b0);
        checks++;
        if (cnt_load !== 1'b1 || cnt_in !== 8'h11 || cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_load got load=%b in=%h en=%b want 1/11/0", cnt_load, cnt_in, cnt_en);
        end
        for (int c = 2; c <= 6; c++) begin
            step();
            checks++;
            if (cnt !== 8'(8'h11 + c - 2) || done !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_run c=%0d got CNT=%h done=%b want %h/0", c, cnt, done, 8'(8'h11 + c - 2));
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || int_cnt !== 8'd1) begin
            errors++;
            $display("FAIL oneshot_done got done=%b int_cnt=%0d want 1/1", done, int_cnt);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cnt !== 8'h15 || int_cnt !== 8'd1) begin
            errors++;
            $display("FAIL oneshot_end got done=%b busy=%b CNT=%h int=%0d want 0/0/15/1", done, busy, cnt, int_cnt);
        end
    endtask

    // Generic interval model: period P = len+2; phase 0 is LOAD, phase k>=1 shows sv+k-1,
    // done is seen at cycles 1+j*P.
    task automatic run_interval(input logic [7:0] sv, input logic [7:0] ev, input logic m, input string tag);
        int len, p_len, last, ph, ndone;
        bit exp_done;
        len   = int'(8'(ev - sv));
        p_len = len + 2;
        last  = m ? (2 * p_len + 1) : (p_len + 2);
        ndone = 0;
        do_start(sv, ev, m);
        for (int c = 1; c <= last; c++) begin
            if (c > 1) step();
            ph       = (c - 1) % p_len;
            exp_done = (c > 1) && (ph == 0) && (m || c == p_len + 1);
            if (exp_done) ndone++;
            if (ph >= 1 && (m || c <= p_len)) begin
                checks++;
                if (cnt !== 8'(sv + 8'(ph - 1))) begin
                    errors++;
                    $display("FAIL %s_cnt c=%0d got %h want %h", tag, c, cnt, 8'(sv + 8'(ph - 1)));
                end
            end
            checks++;
            if (done !== exp_done || int_cnt !== 8'(ndone)) begin
                errors++;
                $display("FAIL %s_done c=%0d got done=%b int=%0d want %b/%0d", tag, c, done, int_cnt, exp_done, ndone);
            end
        end
        if (!m) begin
            checks++;
            if (busy !== 1'b0 || cnt !== ev) begin
                errors++;
                $display("FAIL %s_end got busy=%b CNT=%h want 0/%h", tag, busy, cnt, ev);
            end
        end else begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_abort got busy=%b want 0", tag, busy);
            end
        end
    endtask

    task automatic test_reload_wrap();
        run_interval(8'hFE, 8'h01, 1'b1, "wrap");
        // A third interval on top of the two the generic model covers.
        do_start(8'hFE, 8'h01, 1'b1);
        for (int c = 2; c <= 16; c++) step();
        checks++;
        if (done !== 1'b1 || int_cnt !== 8'd3) begin
            errors++;
            $display("FAIL wrap_third got done=%b int=%0d want 1/3", done, int_cnt);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_hold();
        int done_at;
        done_at = -1;
        do_start(8'h00, 8'h08, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) step();
            if (done === 1'b1 && done_at < 0) done_at = c;
            if (c >= 5 && c <= 9) begin
                checks++;
                if (cnt !== 8'h03 || (c > 5 && cnt_en !== 1'b0)) begin
                    errors++;
                    $display("FAIL hold_frozen c=%0d got CNT=%h en=%b want 03/0", c, cnt, cnt_en);
                end
            end
            hold = (c >= 5 && c <= 8);
        end
        hold = 1'b0;
        checks++;
        if (done_at !== 16 || cnt !== 8'h08) begin
            errors++;
            $display("FAIL hold_delay got done_cycle=%0d CNT=%h want 16/08", done_at, cnt);
        end
    endtask

    task automatic test_abort_reset();
        bit saw_done;
        saw_done = 1'b0;
        do_start(8'h00, 8'h10, 1'b0);
        for (int c = 2; c <= 7; c++) step();
        abort = 1'b1;
        #1;
        checks++;
        if (cnt !== 8'h05 || cnt_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle got CNT=%h en=%b want 05/0", cnt, cnt_en);
        end
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b want 0", busy);
        end
        for (int c = 0; c < 6; c++) begin
            if (done === 1'b1) saw_done = 1'b1;
            step();
        end
        checks++;
        if (saw_done || cnt !== 8'h05 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_after got done_seen=%b CNT=%h busy=%b want 0/05/0", saw_done, cnt, busy);
        end
        // Reset mid-run after one completed auto-reload interval.
        do_start(8'h03, 8'h05, 1'b1);
        for (int c = 2; c <= 7; c++) step();
        checks++;
        if (int_cnt !== 8'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre got int=%0d busy=%b want 1/1", int_cnt, busy);
        end
        res = 1'b1;
        step();
        res = 1'b0;
        checks++;
        if ({busy, done, cnt_en, cnt_load} !== 4'b0000 || cnt_in !== 8'h00 || int_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid got ctl=%b in=%h int=%0d want 0000/00/0", {busy, done, cnt_en, cnt_load}, cnt_in, int_cnt);
        end
    endtask

    task automatic test_corners();
        bit saw_en;
        saw_en = 1'b0;
        do_start(8'h20, 8'h20, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            if (cnt_en === 1'b1) saw_en = 1'b1;
            if (c == 3) begin
                checks++;
                if (done !== 1'b1 || int_cnt !== 8'd1) begin
                    errors++;
                    $display("FAIL zero_len_done got done=%b int=%0d want 1/1", done, int_cnt);
                end
            end
        end
        checks++;
        if (saw_en || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_en got en_seen=%b busy=%b want 0/0", saw_en, busy);
        end

        // start while busy must not disturb the running interval.
        do_start(8'h40, 8'h44, 1'b0);
        step();
        step();
        start_val = 8'h00; end_val = 8'hFF; mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 5; c <= 7; c++) step();
        checks++;
        if (done !== 1'b1 || cnt_in !== 8'h40 || cnt !== 8'h44) begin
            errors++;
            $display("FAIL busy_start got done=%b in=%h CNT=%h want 1/40/44", done, cnt_in, cnt);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_end got busy=%b want 0", busy);
        end

        start_val = 8'h77; end_val = 8'h78; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnt_load !== 1'b0 || cnt_in !== 8'h40) begin
            errors++;
            $display("FAIL start_abort got busy=%b load=%b in=%h want 0/0/40", busy, cnt_load, cnt_in);
        end

        // sv==ev auto-reload: period 2, done at cycles 3,5,7,...
        do_start(8'h00, 8'h00, 1'b1);
        for (int c = 2; c <= 521; c++) begin
            step();
            if (c == 509 || c == 511 || c == 521) begin
                checks++;
                if (int_cnt !== ((c - 1) / 2 > 255 ? 8'd255 : 8'((c - 1) / 2))) begin
                    errors++;
                    $display("FAIL saturate c=%0d got %0d want %0d", c, int_cnt, ((c - 1) / 2 > 255 ? 255 : (c - 1) / 2));
                end
            end
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] sv, ev;
        logic       m;
        for (int i = 0; i < 16; i++) begin
            sv = 8'($urandom);
            ev = (i % 4 == 0) ? 8'(sv + 8'($urandom_range(0, 6))) : 8'($urandom);
            m  = 1'($urandom_range(0, 1));
            run_interval(sv, ev, m, "rand");
            step();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_oneshot();
        test_reload_wrap();
        test_hold();
        test_abort_reset();
        test_corners();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/count_seq.md
Name: count_seq

Overview:
- Sequencer/controller for the team's 8-bit loadable up-counter (count8 family: clk, res, EN, load, CNT_In, CNT).
- Accepts an interval command (start value, end value, mode) and drives the counter's load/EN so that it counts from start to end.
- Pulses done at terminal, supports one-shot and auto-reload modes, pause (hold) and abort.
- Sits between a control requester and one counter instance; the counter itself is external.

Parameters:
- WIDTH, 8, counter/data width
- INT_W, 8, width of completed-interval counter

Ports:
- clk  in  1  system clock, rising edge
- res  in  1  synchronous reset, active-high
- start  in  1  command strobe; sampled only in IDLE
- mode  in  1  0 = one-shot, 1 = auto-reload; latched on start
- hold  in  1  pause request (level)
- abort  in  1  cancel current operation (level, sampled each cycle)
- start_val  in  WIDTH  preload value; latched on start
- end_val  in  WIDTH  terminal value; latched on start
- CNT  in  WIDTH  current counter value, fed back from the counter
- CNT_EN  out  1  counter enable
- CNT_load  out  1  counter synchronous load
- CNT_In  out  WIDTH  counter load data
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse per completed interval
- int_cnt  out  INT_W  completed intervals since last start; saturating

Behaviour:
- Counter contract: load has priority over EN; CNT increments mod 2^WIDTH on each EN edge. load/EN take effect at the edge ending the cycle in which they are driven.
- Reset (res=1 at a clk edge): state=IDLE. sv_r, ev_r, mode_r, int_cnt cleared to 0. done=0, busy=0, CNT_EN=0, CNT_load=0, CNT_In=0. Reset has priority over every other input, including mid-interval.
- States: IDLE, LOAD, RUN, PAUSE, DONE. The state register is updated on clk.
- IDLE:
  - start=1 and abort=0 → latch sv_r/ev_r/mode_r, clear int_cnt, go to LOAD.
  - start is ignored in every other state.
- LOAD: CNT_load=1, CNT_In=sv_r, CNT_EN=0, for exactly 1 cycle → RUN.
- RUN:
  - Match condition: CNT==ev_r.
  - CNT_EN = (state==RUN) & ~hold & (CNT != ev_r). This is combinational from the registered state and CNT, so the counter stops exactly on ev_r.
  - Match has priority over hold.
  - On match, mode_r=0 → DONE.
  - On match, mode_r=1 → LOAD. That transition also raises done and increments int_cnt.
  - No match and hold=1 → PAUSE.
- PAUSE: CNT_EN=0. hold=0 → RUN. The count resumes from the frozen value with no lost or extra increment.
- DONE: 1 cycle, done=1, int_cnt += 1, → IDLE.
- done is registered: high the cycle after the match cycle, for one cycle only.
- Interval length: (ev_r − sv_r) mod 2^WIDTH increments. Wrap FF→00 is legal.
- sv==ev: match on the first RUN cycle, zero increments, done still pulses.
- Auto-reload period = 1 (LOAD) + length + 1 (RUN match cycle) cycles.
- abort=1 in LOAD/RUN/PAUSE/DONE → IDLE next cycle.
  - During an abort cycle: CNT_EN=0 and CNT_load=0.
  - abort beats a same-cycle match: no done pulse, int_cnt unchanged.
  - abort in IDLE blocks start.
- int_cnt saturates at 2^INT_W−1. It holds its value in IDLE.
- CNT_In holds sv_r outside LOAD. CNT_load=0 outside LOAD.

Decomposition:
- Shared package count_pkg holds:
  - state enum (IDLE, LOAD, RUN, PAUSE, DONE)
  - WIDTH default
  - MODE_ONESHOT / MODE_RELOAD constants
- No sub-module inside count_seq.
- The bench instantiates the count8 counter as a sibling and closes the CNT feedback loop.

Test Plan:
- One-shot: res, then start (sv=0x11, ev=0x15, mode=0) at cycle 0.
  - Cycle 1: CNT_load=1.
  - CNT=0x11 at cycle 2, 0x15 at cycle 6.
  - done=1 at cycle 7 only; busy=0 at cycle 8; int_cnt=1; CNT stays 0x15.
- Auto-reload wrap: sv=0xFE, ev=0x01, mode=1.
  - CNT sequence FE, FF, 00, 01.
  - done every 5 cycles; int_cnt 1, 2, 3 after the first three intervals.
- Hold: one-shot 0x00→0x08, hold=1 for 4 cycles while CNT=0x03.
  - CNT frozen at 0x03 throughout the hold.
  - done is delayed by exactly 4 cycles (+1 PAUSE entry) versus the no-hold run; final CNT=0x08.
- Abort and reset mid-run:
  - abort at CNT=0x05 (sv=0, ev=0x10) → busy=0 next cycle, no done, CNT frozen at 0x05.
  - Repeat with res=1 instead → all outputs 0 and int_cnt=0.
- Corner cases:
  - sv=ev=0x20 → done pulse, CNT_EN never 1.
  - start asserted while busy → ignored, latched values unchanged.
  - start and abort together in IDLE → stays IDLE.
  - After 256 auto-reload intervals, int_cnt=0xFF (saturated).
